specmd_pipe: RTL
================

// Module: specmd_pipe
// PURPOSE
//  Pipelined special-case resolver for the FP multiply/divide datapath, width-parametrised.
//  - Classifies operand flag pairs: zero, infinity, quiet NaN, signalling NaN.
//  - Produces result class, invalid / divide-by-zero exceptions and the NaN significand.
//  - Sits in parallel with the mul/div significand path; the rounder takes flq when any class bit is set.
// PARAMETERS
//  FRAC_W  52  stored fraction width; significand is FRAC_W+1 bits (52 double, 23 single)
//  STAGES  2   pipeline depth, legal 1..4; latency in cycles with no stall
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst_n      in   1         synchronous reset, active-low
//  in_valid   in   1         operand set valid
//  in_ready   out  1         pipe accepts operand set this cycle
//  fdiv       in   1         1 = divide a/b, 0 = multiply a*b
//  sa, sb     in   1 each    operand signs
//  fla, flb   in   4 each    flags [3]=ZERO [2]=INF [1]=QNAN [0]=SNAN (at most one set)
//  nan_a      in   FRAC_W+1  significand of a (meaningful when a is NaN)
//  nan_b      in   FRAC_W+1  significand of b (meaningful when b is NaN)
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts result
//  sq         out  1         result sign = sa^sb (forced 0 for NaN results)
//  flq        out  FRAC_W+6  {ZERO,INF,NAN,INV,DBZ,sig[FRAC_W:0]}; 58 bits at default
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all stage valids 0, out_valid=0, flq=0, sq=0.
//    in_ready=1 from the first cycle after reset; in-flight entries are discarded.
//  - Handshake: transfer on valid&&ready at each end.
//    - Stage k loads when it is empty or stage k+1 loads / output handshakes.
//    - in_ready = !v[0] || stage0 advances (combinational from out_ready through the chain).
//    - While out_valid && !out_ready: flq, sq, out_valid are held stable; no entry is lost or duplicated.
//  - Throughput 1 per cycle; latency exactly STAGES cycles from input handshake to out_valid.
//  - Classification happens in stage 0 and is registered. Later stages are pure delay.
//    Let nA = a QNAN|SNAN, nB likewise, fin = !INF && !NaN. Priority NaN > INF > ZERO:
//    - INV = SNAN in a or b; or mul ZERO*INF (either order); or div 0/0 or INF/INF.
//    - NAN = nA | nB | INV. sig = nan_a if nA, else nan_b if nB, else canonical {2'b11,0..}.
//      Bit FRAC_W-1 is forced 1 (quieted).
//    - DBZ = fdiv && a fin nonzero && b ZERO. DBZ implies INF.
//    - INF (no NAN) = mul: any INF operand with other nonzero; div: a INF & b fin, or DBZ.
//    - ZERO (no NAN) = mul: any ZERO with other fin; div: a ZERO & b nonzero, or a fin & b INF.
//    - Neither side special: flq=0 (no special case; rounder uses the datapath result).
//    - ZERO/INF/NAN are mutually exclusive. sig=0 unless NAN.
//  - Illegal flag input (more than one bit set) is out of contract; the assertion fires (sim only).
// CONFIGURATION
//  SPECMD_STICKY_EN defined:
//    - Adds ports clr_sticky (in,1), sticky_inv (out,1), sticky_dbz (out,1), all reset to 0.
//    - On each output handshake, sticky_x |= flq.x.
//    - clr_sticky zeroes both the next cycle. Clear with a same-cycle INV/DBZ handshake leaves that bit set.
//  Undefined: these ports and registers do not exist; the rest is identical.
// STRUCTURE
//  - specmd_pkg holds:
//    - flag index localparams FL_ZERO=3, FL_INF=2, FL_QNAN=1, FL_SNAN=0;
//    - flq field offsets as functions of FRAC_W;
//    - a typedef for the 4-bit flag vector;
//    - function specmd_classify().
//  - Sub-module specmd_stage: one valid/data register slot with load/hold, instantiated STAGES times.
// TESTING
//  1. Reset mid-stream: 3 ops in flight, rst_n low 1 cycle -> out_valid=0, flq=0; no stale result afterwards.
//  2. mul, fla=1000 (ZERO), flb=0100 (INF) -> after STAGES cycles flq NAN=1, INV=1,
//     sig=53'h18000000000000, sq=0.
//  3. div, fla=0000, flb=1000, sa=1, sb=0 -> INF=1, DBZ=1, sq=1, sig=0.
//  4. div, fla=0001 (SNAN), nan_a=53'h10000000000005, flb=0010 -> NAN=1, INV=1,
//     sig=53'h18000000000005.
//  5. Back-to-back 8 ops, out_ready low cycles 3-5 -> in_ready drops once pipe full; flq held;
//     all 8 results in order, none dropped.
//  6. SPECMD_STICKY_EN: DBZ op, then clr_sticky with a same-cycle INV handshake
//     -> sticky_dbz 1 then 0, sticky_inv 1.

Source files
------------

// File: rtl/specmd_pkg.sv
// specmd_pkg: shared definitions for the FP mul/div special-case resolver.
// Latency: n/a (types, constants and a combinational classifier only).
// Backpressure: n/a.
// Contents: flag bit indices, flq field offsets as functions of FRAC_W, the
// 4-bit flag vector type, the class struct and specmd_classify().
package specmd_pkg;

  // Operand flag bit positions; at most one is set per operand.
  localparam int FL_ZERO = 3;
  localparam int FL_INF  = 2;
  localparam int FL_QNAN = 1;
  localparam int FL_SNAN = 0;

  typedef logic [3:0] fl_t;

  // Field order matches the top five bits of flq: {ZERO,INF,NAN,INV,DBZ}.
  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic inv;
    logic dbz;
  } cls_t;

  // flq layout: {ZERO,INF,NAN,INV,DBZ,sig[FRAC_W:0]}
  function automatic int flq_width(input int frac_w);
    return frac_w + 6;
  endfunction

  function automatic int flq_dbz(input int frac_w);
    return frac_w + 1;
  endfunction

  function automatic int flq_inv(input int frac_w);
    return frac_w + 2;
  endfunction

  function automatic int flq_nan(input int frac_w);
    return frac_w + 3;
  endfunction

  function automatic int flq_inf(input int frac_w);
    return frac_w + 4;
  endfunction

  function automatic int flq_zero(input int frac_w);
    return frac_w + 5;
  endfunction

  // Resolves the result class from the operand flags. Priority is
  // NaN > INF > ZERO, so INF and ZERO are masked whenever NAN is set.
  function automatic cls_t specmd_classify(input logic fdiv, input fl_t fla, input fl_t flb);
    cls_t r;
    logic na, nb, za, zb, ia, ib, fa, fb;
    na = fla[FL_QNAN] | fla[FL_SNAN];
    nb = flb[FL_QNAN] | flb[FL_SNAN];
    za = fla[FL_ZERO];
    zb = flb[FL_ZERO];
    ia = fla[FL_INF];
    ib = flb[FL_INF];
    fa = !ia && !na;
    fb = !ib && !nb;
    r.inv  = fla[FL_SNAN] | flb[FL_SNAN] |
             (fdiv ? ((za && zb) || (ia && ib)) : ((za && ib) || (ia && zb)));
    r.nan  = na | nb | r.inv;
    // A finite nonzero dividend over zero can never also be a NaN case.
    r.dbz  = fdiv && fa && !za && zb;
    r.inf  = !r.nan && (fdiv ? ((ia && fb) || r.dbz) : ((ia && !zb) || (ib && !za)));
    r.zero = !r.nan && (fdiv ? ((za && !zb) || (fa && ib)) : ((za && fb) || (zb && fa)));
    return r;
  endfunction

endpackage

// File: rtl/specmd_stage.sv
// specmd_stage: one valid/data pipeline slot with load/hold.
// Latency: 1 cycle when loaded.
// Backpressure: holds valid and data while load is low; data only updates on valid loads.
// Ports: clk, rst_n (sync, active-low), load (slot accepts in_v/in_d),
//        in_v/in_d (upstream slot), v/d (registered slot contents).
module specmd_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         v,
  output logic [W-1:0] d
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else if (load) begin
      v <= in_v;
      // Bubbles do not disturb the data register.
      if (in_v) d <= in_d;
    end
  end

endmodule

// File: rtl/specmd_pipe.sv
// specmd_pipe: pipelined special-case resolver for the FP multiply/divide path.
// Latency: STAGES cycles (legal 1..4) from input handshake to out_valid, 1 op/cycle.
// Backpressure: valid/ready chain; in_ready falls combinationally from out_ready when full.
// Parameters: FRAC_W stored fraction width, STAGES pipeline depth.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, fdiv, sa, sb, fla, flb,
//        nan_a, nan_b on the input side; out_valid/out_ready, sq, flq on the output
//        side, flq = {ZERO,INF,NAN,INV,DBZ,sig[FRAC_W:0]}.
// Build option SPECMD_STICKY_EN adds clr_sticky (in), sticky_inv, sticky_dbz (out):
// exception bits accumulated over output handshakes.
module specmd_pipe
  import specmd_pkg::*;
#(
  parameter int FRAC_W = 52,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fdiv,
  input  logic              sa,
  input  logic              sb,
  input  logic [3:0]        fla,
  input  logic [3:0]        flb,
  input  logic [FRAC_W:0]   nan_a,
  input  logic [FRAC_W:0]   nan_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sq,
  output logic [FRAC_W+5:0] flq
`ifdef SPECMD_STICKY_EN
  ,
  input  logic              clr_sticky,
  output logic              sticky_inv,
  output logic              sticky_dbz
`endif
);

  localparam int FLQ_W = flq_width(FRAC_W);
  localparam int DW    = FLQ_W + 1;  // {sq, flq}

  cls_t            cls;
  logic            na, nb;
  logic [FRAC_W:0] sig;
  logic [DW-1:0]   d_in;

  // Stage-0 classification; everything after it is pure delay.
  always_comb begin
    cls = specmd_classify(fdiv, fla, flb);
    na  = fla[FL_QNAN] | fla[FL_SNAN];
    nb  = flb[FL_QNAN] | flb[FL_SNAN];
    sig = '0;
    if (cls.nan) begin
      if (na) begin
        sig = nan_a;
      end else if (nb) begin
        sig = nan_b;
      end else begin
        sig[FRAC_W] = 1'b1;
      end
      // Quiet bit: propagated signalling NaNs come out quiet.
      sig[FRAC_W-1] = 1'b1;
    end
    d_in = {(sa ^ sb) & ~cls.nan, cls, sig};
  end

  logic [STAGES-1:0] v;
  logic [DW-1:0]     d [STAGES];
  logic [STAGES:0]   en;

  // en[k]: slot k loads this cycle. A slot loads if empty or if its
  // occupant moves on; en[STAGES] is the output handshake.
  always_comb begin
    en         = '0;
    en[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = !v[k] || en[k+1];
    end
  end

  assign in_ready = en[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      specmd_stage #(.W(DW)) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .load (en[0]),
        .in_v (in_valid),
        .in_d (d_in),
        .v    (v[0]),
        .d    (d[0])
      );
    end else begin : g_next
      specmd_stage #(.W(DW)) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .load (en[k]),
        .in_v (v[k-1]),
        .in_d (d[k-1]),
        .v    (v[k]),
        .d    (d[k])
      );
    end
  end

  assign out_valid = v[STAGES-1];
  assign sq        = d[STAGES-1][DW-1];
  assign flq       = d[STAGES-1][FLQ_W-1:0];

`ifdef SPECMD_STICKY_EN
  logic out_hs;
  assign out_hs = out_valid & out_ready;

  // A clear and a same-cycle handshake: the clear applies to the old value,
  // the new exception still lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_inv <= 1'b0;
      sticky_dbz <= 1'b0;
    end else begin
      sticky_inv <= (sticky_inv & ~clr_sticky) | (out_hs & flq[flq_inv(FRAC_W)]);
      sticky_dbz <= (sticky_dbz & ~clr_sticky) | (out_hs & flq[flq_dbz(FRAC_W)]);
    end
  end
`endif

  // Operand flags are one-hot or empty; anything else is out of contract.
  a_flags_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> ($onehot0(fla) && $onehot0(flb)));

endmodule
